// File: rtl/dfs_freq_sequencer.sv
// dfs_freq_sequencer: drives the DFS reconfiguration port through a frequency table
// using sequential, LFSR-random or fixed selection, with dwell time, ack timeout and change count.
module dfs_freq_sequencer #(
    parameter int DATA_WIDTH = 13,
    parameter int N_FREQ = 6,
    parameter logic [N_FREQ-1:0][31:0] FREQS = {32'd480, 32'd440, 32'd400, 32'd360, 32'd320, 32'd280},
    parameter int DWELL_WIDTH = 16,
    parameter int TIMEOUT = 1024,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int IW = (N_FREQ > 1) ? $clog2(N_FREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic [1:0]             mode_i,
    input  logic [IW-1:0]          fixed_idx_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    output logic                   freqChanger2dfs_en,
    output logic [DATA_WIDTH-1:0]  freqChanger2dfs_data,
    input  logic                   dfs2freqChanger_ack,
    output logic [IW-1:0]          cur_idx_o,
    output logic                   busy_o,
    output logic                   timeout_err_o,
    output logic [15:0]            change_cnt_o
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_FREQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ACK, S_DWELL} state_t;

    state_t                 state, state_d;
    logic                   en_q, en_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [IW-1:0]          pend_q, pend_d;
    logic [IW-1:0]          cur_q, cur_d;
    logic                   first_q, first_d;
    logic                   err_q, err_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [DWELL_WIDTH-1:0] dcnt_q, dcnt_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   busy_q;
    logic                   issue;
    logic [IW-1:0]          nxt_seq, r_raw, r_mod, rnd_idx, fix_idx, sel_idx;

    always_comb begin
        nxt_seq = (cur_q == I_LAST) ? '0 : cur_q + IW'(1);
        r_raw   = lfsr_q[IW-1:0];
        r_mod   = (r_raw > I_LAST) ? r_raw - IW'(N_FREQ) : r_raw;
        // Random mode never repeats the frequency it is already running at.
        rnd_idx = (r_mod == cur_q && N_FREQ > 1) ? nxt_seq : r_mod;
        fix_idx = (fixed_idx_i > I_LAST) ? I_LAST : fixed_idx_i;
        sel_idx = (mode_i == 2'd0) ? (first_q ? '0 : nxt_seq) :
                  (mode_i == 2'd1) ? rnd_idx : fix_idx;
        lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    end

    always_comb begin
        state_d = state;
        en_d    = 1'b0;
        data_d  = data_q;
        pend_d  = pend_q;
        cur_d   = cur_q;
        first_d = first_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;
        issue   = 1'b0;
        case (state)
            S_IDLE: begin
                issue = enable_i;
                err_d = enable_i ? err_q : 1'b0;
            end
            S_WAIT_ACK: begin
                if (dfs2freqChanger_ack) begin
                    cur_d   = pend_q;
                    first_d = 1'b0;
                    cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                    dcnt_d  = (dwell_i == '0) ? DWELL_WIDTH'(1) : dwell_i;
                    state_d = S_DWELL;
                end else if (tcnt_q == T_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_DWELL: begin
                if (dcnt_q == DWELL_WIDTH'(1)) begin
                    issue   = enable_i;
                    state_d = enable_i ? state : S_IDLE;
                end else begin
                    dcnt_d = dcnt_q - DWELL_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            en_d    = 1'b1;
            data_d  = FREQS[sel_idx][DATA_WIDTH-1:0];
            pend_d  = sel_idx;
            tcnt_d  = '0;
            state_d = S_WAIT_ACK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            en_q    <= 1'b0;
            data_q  <= '0;
            pend_q  <= '0;
            cur_q   <= '0;
            first_q <= 1'b1;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            dcnt_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_d;
            en_q    <= en_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            first_q <= first_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            dcnt_q  <= dcnt_d;
            lfsr_q  <= lfsr_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign freqChanger2dfs_en   = en_q;
    assign freqChanger2dfs_data = data_q;
    assign cur_idx_o            = cur_q;
    assign busy_o               = busy_q;
    assign timeout_err_o        = err_q;
    assign change_cnt_o         = cnt_q;
endmodule

// File: tb/tb_dfs_freq_sequencer.sv
// tb_dfs_freq_sequencer: directed scenarios with an event-level reference model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_dfs_freq_sequencer;
    localparam int DW = 13;
    localparam int N = 6;
    localparam int IW = 3;
    localparam int TO = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic ack = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [IW-1:0] fixed_idx = '0;
    logic [15:0] dwell = 16'd4;
    logic en, busy, err;
    logic [DW-1:0] data;
    logic [IW-1:0] cur;
    logic [15:0] cnt;

    int vecs = 0, miss = 0, cyc = 0, ack_delay = 2, cd = -1, last_cnt = 0;
    int q_data[$], q_cyc[$], q_cur[$];
    int freqs[N] = '{280, 320, 360, 400, 440, 480};

    int ph, waited, dleft, m_en, m_data, m_cur, m_first, m_err, m_cnt, m_pend;
    logic [15:0] m_lfsr;

    dfs_freq_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .mode_i(mode), .fixed_idx_i(fixed_idx),
        .dwell_i(dwell), .freqChanger2dfs_en(en), .freqChanger2dfs_data(data),
        .dfs2freqChanger_ack(ack), .cur_idx_o(cur), .busy_o(busy),
        .timeout_err_o(err), .change_cnt_o(cnt)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DFS stand-in: acks ack_delay cycles after each request pulse (never when negative).
    always @(posedge clk) begin
        #2;
        if (en === 1'b1 && ack_delay >= 0) cd = ack_delay;
        else if (cd >= 0) cd--;
        ack = (cd == 0);
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        vecs++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, got, want);
        end
    endtask

    function automatic int pick();
        int r;
        if (mode == 2'd0) return m_first ? 0 : (m_cur + 1) % N;
        if (mode == 2'd1) begin
            r = int'(m_lfsr % 16'd8);
            if (r >= N) r -= N;
            if (r == m_cur) r = (m_cur + 1) % N;
            return r;
        end
        return (fixed_idx > N - 1) ? N - 1 : int'(fixed_idx);
    endfunction

    task automatic model_reset();
        ph = 0; waited = 0; dleft = 0; m_en = 0; m_data = 0; m_cur = 0;
        m_first = 1; m_err = 0; m_cnt = 0; m_pend = 0; m_lfsr = SEED;
    endtask

    // ph: 0 idle, 1 waiting for ack, 2 dwelling
    task automatic model_step();
        bit go = 0;
        if (ph == 0) begin
            if (enable) go = 1;
            else m_err = 0;
        end else if (ph == 1) begin
            if (ack) begin
                m_cur = m_pend; m_first = 0;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                dleft = (dwell == 0) ? 1 : int'(dwell);
                ph = 2;
            end else if (waited + 1 == TO) begin
                m_err = 1; ph = 0;
            end else waited++;
        end else begin
            if (dleft == 1) begin
                if (enable) go = 1;
                else ph = 0;
            end else dleft--;
        end
        if (go) begin
            m_pend = pick(); m_data = freqs[m_pend]; waited = 0; ph = 1;
        end
        m_en = go;
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) begin
                model_reset();
                last_cnt = 0;
            end
            check("en", en, m_en);
            check("data", data, m_data);
            check("cur_idx", cur, m_cur);
            check("busy", busy, ph != 0);
            check("timeout_err", err, m_err);
            check("change_cnt", cnt, m_cnt);
            if (en === 1'b1) begin q_data.push_back(int'(data)); q_cyc.push_back(cyc); end
            if (int'(cnt) != last_cnt) begin q_cur.push_back(int'(cur)); last_cnt = int'(cnt); end
            if (!rst) model_step();
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_pulses(int n, int lim);
        int i = 0;
        while (q_data.size() < n && i < lim) begin tick(); i++; end
        if (q_data.size() < n) begin
            vecs++; miss++;
            $display("FAIL wait_pulses got %0d pulses want %0d", q_data.size(), n);
        end
    endtask

    task automatic wait_en(output int c);
        int i = 0;
        do begin tick(); i++; end while (en !== 1'b1 && i < 60);
        if (en !== 1'b1) begin
            vecs++; miss++;
            $display("FAIL wait_en got no pulse want pulse");
        end
        c = cyc;
    endtask

    task automatic zero_check(string tag);
        check({tag, "_en"}, en, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_cur"}, cur, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cnt"}, cnt, 0);
    endtask

    initial begin
        int e, bad_range, bad_rep;
        int exp1[7] = '{280, 320, 360, 400, 440, 480, 280};
        tick(3);
        zero_check("reset");

        // T1: sequential walk with wrap
        q_data.delete(); q_cyc.delete();
        mode = 2'd0; dwell = 16'd4; ack_delay = 2; enable = 1'b1; rst = 1'b0;
        wait_pulses(7, 200);
        enable = 1'b0;
        tick(12);
        for (int i = 0; i < 7; i++) check("t1_data", q_data[i], exp1[i]);
        for (int i = 1; i < 7; i++) check("t1_gap", q_cyc[i] - q_cyc[i-1], 7);
        check("t1_cnt", cnt, 7);
        check("t1_cur", cur, 0);
        check("t1_busy", busy, 0);

        // T2: fixed index beyond the table clamps to the last entry
        q_data.delete(); q_cyc.delete();
        mode = 2'd2; fixed_idx = 3'd7; enable = 1'b1;
        wait_pulses(3, 100);
        enable = 1'b0;
        tick(12);
        for (int i = 0; i < 3; i++) check("t2_data", q_data[i], 480);
        check("t2_cur", cur, 5);

        // T4: no ack -> timeout after TO cycles, error clears once idle with enable low
        mode = 2'd0; ack_delay = -1; enable = 1'b1;
        wait_en(e);
        enable = 1'b0;
        check("t4_data", data, 280);
        for (int i = 0; i < 40 && err !== 1'b1; i++) tick();
        check("t4_err_delay", cyc - e, 16);
        check("t4_err", err, 1);
        check("t4_busy", busy, 0);
        check("t4_cur", cur, 5);
        tick();
        check("t4_err_clear", err, 0);

        // T5: enable dropped while waiting; late ack still completes, then idle
        q_data.delete(); q_cyc.delete();
        ack_delay = 10; dwell = 16'd3; enable = 1'b1;
        wait_en(e);
        enable = 1'b0;
        tick(30);
        check("t5_pulses", q_data.size(), 1);
        check("t5_data", q_data[0], 280);
        check("t5_cur", cur, 0);
        check("t5_cnt", cnt, 11);
        check("t5_busy", busy, 0);

        // T6a: reset during dwell
        ack_delay = 2; dwell = 16'd8; enable = 1'b1;
        wait_en(e);
        check("t6a_data", data, 320);
        tick(5);
        rst = 1'b1;
        #1 zero_check("t6a_rst");
        tick(2);
        rst = 1'b0;
        wait_en(e);
        enable = 1'b0;
        check("t6a_first", data, 280);
        tick(15);

        // T6b: reset during ack wait; the abandoned ack lands in idle and is ignored
        ack_delay = 5; enable = 1'b1;
        wait_en(e);
        enable = 1'b0;
        tick(2);
        rst = 1'b1;
        #1 zero_check("t6b_rst");
        tick();
        rst = 1'b0;
        tick(6);
        check("t6b_cnt", cnt, 0);
        check("t6b_busy", busy, 0);
        ack_delay = 2; enable = 1'b1;
        wait_en(e);
        enable = 1'b0;
        check("t6b_first", data, 280);
        tick(12);
        check("t6b_cnt_after", cnt, 1);

        // T3: random mode from a fresh seed
        rst = 1'b1;
        tick(2);
        q_data.delete(); q_cyc.delete(); q_cur.delete();
        mode = 2'd1; dwell = 16'd4; ack_delay = 2; enable = 1'b1; rst = 1'b0;
        for (int i = 0; i < 3000 && q_cur.size() < 200; i++) tick();
        enable = 1'b0;
        tick(12);
        check("t3_changes", q_cur.size() >= 200, 1);
        check("t3_data0", q_data[0], 320);
        check("t3_data1", q_data[1], 360);
        check("t3_idx0", q_cur[0], 1);
        check("t3_idx1", q_cur[1], 2);
        bad_range = 0; bad_rep = 0;
        foreach (q_cur[i]) begin
            if (q_cur[i] >= N) bad_range++;
            if (i > 0 && q_cur[i] == q_cur[i-1]) bad_rep++;
        end
        check("t3_range", bad_range, 0);
        check("t3_repeat", bad_rep, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
